// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, burst-limited arbiter for the write port of the
//            async FIFO. NREQ producers in the write-clock domain share the
//            port. Each grant carries up to BURST words, then priority
//            rotates. FIFO-full back-pressure is honoured with a
//            zero-latency accept path.
// Ports    : w_clk    - write-domain clock
//            w_rst    - synchronous, active-high reset
//            en       - arbitration enable (gates only new grants)
//            req      - per-requester "word available" flags
//            data_in  - packed words, requester i at [i*DATASIZE +: DATASIZE]
//            wfull    - FIFO full flag (write domain)
//            ack      - one-hot accept strobe to the granted requester
//            w_inc    - FIFO write strobe
//            wdata    - FIFO write data (zero when no write)
//            busy     - high while a grant is held
//            grant_id - current / last granted requester
//            wr_count - total words written, wraps
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int BURST    = 4,
    parameter int CNTW     = 16
) (
    input  logic                       w_clk,
    input  logic                       w_rst,
    input  logic                       en,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DATASIZE-1:0]   data_in,
    input  logic                       wfull,
    output logic [NREQ-1:0]            ack,
    output logic                       w_inc,
    output logic [DATASIZE-1:0]        wdata,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic [CNTW-1:0]            wr_count
);

    localparam int IDW = $clog2(NREQ);
    localparam int BW  = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0]  C_BURST_LAST = BW'(BURST - 1);
    localparam logic [IDW-1:0] C_LAST_RST   = IDW'(NREQ - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              state_q;
    logic [IDW-1:0]      grant_q;
    logic [IDW-1:0]      last_q;
    logic [BW-1:0]       burst_q;
    logic [CNTW-1:0]     wr_count_q;

    logic                req_sel;
    logic [DATASIZE-1:0] data_sel;
    logic                xfer;
    logic                pick_found;
    logic [IDW-1:0]      pick_id;

    // Route the granted requester's request bit and data word.
    always_comb begin
        req_sel  = 1'b0;
        data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDW'(i)) begin
                req_sel  = req[i];
                data_sel = data_in[i*DATASIZE +: DATASIZE];
            end
        end
    end

    // Accept is combinational so a word is never pushed while the FIFO is
    // full; reset also blocks it so nothing is written in a reset cycle.
    always_comb begin
        xfer = (state_q == S_GRANT) && req_sel && !wfull && !w_rst;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = xfer && (grant_q == IDW'(i));
        end
        w_inc = xfer;
        wdata = xfer ? data_sel : '0;
        busy  = (state_q == S_GRANT) && !w_rst;
    end

    // Round-robin pick: first requester found scanning last+1, last+2, ...
    // modulo NREQ. Outer loop is the scan distance, inner loop finds the
    // requester at that distance, so indices into req stay constant.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_found && req[i] && (((int'(last_q) + k) % NREQ) == i)) begin
                    pick_found = 1'b1;
                    pick_id    = IDW'(i);
                end
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_q     <= C_LAST_RST;
            burst_q    <= '0;
            wr_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en && pick_found) begin
                        grant_q <= pick_id;
                        burst_q <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (xfer) begin
                        wr_count_q <= wr_count_q + CNTW'(1);
                        burst_q    <= burst_q + BW'(1);
                        if (burst_q == C_BURST_LAST) begin
                            state_q <= S_IDLE;
                            last_q  <= grant_q;
                        end
                    end else if (!req_sel) begin
                        // Requester withdrew: it forfeits the rest of its burst.
                        state_q <= S_IDLE;
                        last_q  <= grant_q;
                    end
                    // wfull with req held: stall, burst count unchanged.
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_id = grant_q;
    assign wr_count = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter. Per-requester producer
//            queues drive req/data_in; the expected FIFO write order is
//            queued when stimulus is loaded and compared on every write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int CNTW  = 16;

    logic              clk = 1'b0;
    logic              w_rst;
    logic              en;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] data_in;
    logic              wfull;
    logic [NREQ-1:0]   ack;
    logic              w_inc;
    logic [DW-1:0]     wdata;
    logic              busy;
    logic [1:0]        grant_id;
    logic [CNTW-1:0]   wr_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef logic [DW-1:0] word_q_t[$];
    word_q_t prod[NREQ];

    logic            obs_winc;
    logic            obs_busy;
    logic [1:0]      obs_gid;
    logic [CNTW-1:0] obs_count;
    logic [NREQ-1:0] obs_ack;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DATASIZE(DW), .BURST(BURST), .CNTW(CNTW)
    ) dut (
        .w_clk(clk), .w_rst(w_rst), .en(en), .req(req), .data_in(data_in),
        .wfull(wfull), .ack(ack), .w_inc(w_inc), .wdata(wdata), .busy(busy),
        .grant_id(grant_id), .wr_count(wr_count)
    );

    // Present the head of each producer queue to the DUT.
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (prod[i].size() > 0) begin
                req[i]              = 1'b1;
                data_in[i*DW +: DW] = prod[i][0];
            end else begin
                req[i]              = 1'b0;
                data_in[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic load(input int id, input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) prod[id].push_back(base + DW'(k));
    endtask

    task automatic expect_words(input int id, input logic [DW-1:0] base, input int n);
        sb_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = id;
            e.data = base + DW'(k);
            sb_q.push_back(e);
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < NREQ; i++) prod[i].delete();
        sb_q.delete();
        drive();
    endtask

    // One clock cycle: sample at negedge, score any write, then advance the
    // producers past the edge and re-drive inputs.
    task automatic tick();
        sb_t             e;
        logic [NREQ-1:0] ea;
        @(negedge clk);
        obs_winc  = w_inc;
        obs_busy  = busy;
        obs_gid   = grant_id;
        obs_count = wr_count;
        obs_ack   = ack;
        checks++;
        if (w_inc === 1'b1) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got id=%0d data=%h, expected no write", grant_id, wdata);
            end else begin
                e  = sb_q.pop_front();
                ea = '0;
                ea[e.id] = 1'b1;
                if (wdata !== e.data || ack !== ea || grant_id !== 2'(e.id) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL write: got id=%0d data=%h ack=%b busy=%b, expected id=%0d data=%h ack=%b busy=1",
                             grant_id, wdata, ack, busy, e.id, e.data, ea);
                end
            end
        end else if (w_inc !== 1'b0 || ack !== '0 || wdata !== '0) begin
            errors++;
            $display("FAIL idle_strobe: got w_inc=%b ack=%b wdata=%h, expected 0/0000/00", w_inc, ack, wdata);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (obs_ack[i] === 1'b1 && prod[i].size() > 0) prod[i].delete(0);
        end
        drive();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d writes outstanding, expected 0", name, sb_q.size());
        end
    endtask

    task automatic do_reset();
        flush_all();
        w_rst = 1'b1;
        en    = 1'b1;
        wfull = 1'b0;
        tick();
        tick();
        w_rst = 1'b0;
    endtask

    task automatic test_reset();
        flush_all();
        w_rst = 1'b1;
        en    = 1'b1;
        wfull = 1'b0;
        load(2, 8'hEE, 1);   // request pending during reset: must not be acked
        drive();
        tick();
        tick();
        checks++;
        if (obs_busy !== 1'b0 || obs_winc !== 1'b0 || obs_gid !== 2'd0 || obs_count !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b w_inc=%b gid=%0d count=%0d, expected 0/0/0/0",
                     obs_busy, obs_winc, obs_gid, obs_count);
        end
        flush_all();
        w_rst = 1'b0;
    endtask

    task automatic test_single_requester();
        logic [9:0] pat;
        do_reset();
        pat = 10'b1111011110;
        load(0, 8'h10, 8);
        expect_words(0, 8'h10, 8);
        drive();
        for (int t = 0; t < 11; t++) begin
            tick();
            if (t < 10) begin
                checks++;
                if (obs_winc !== pat[t]) begin
                    errors++;
                    $display("FAIL single_pattern t=%0d: got w_inc=%b, expected %b", t, obs_winc, pat[t]);
                end
            end
        end
        checks++;
        if (obs_count !== 16'd8 || obs_winc !== 1'b0) begin
            errors++;
            $display("FAIL single_count: got wr_count=%0d w_inc=%b, expected 8/0", obs_count, obs_winc);
        end
        check_drained("single");
    endtask

    task automatic test_round_robin();
        do_reset();
        load(0, 8'h20, 8);
        load(1, 8'h30, 4);
        load(2, 8'h40, 4);
        load(3, 8'h50, 4);
        expect_words(0, 8'h20, 4);
        expect_words(1, 8'h30, 4);
        expect_words(2, 8'h40, 4);
        expect_words(3, 8'h50, 4);
        expect_words(0, 8'h24, 4);
        drive();
        for (int t = 0; t < 26; t++) tick();
        checks++;
        if (obs_count !== 16'd20 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_count: got wr_count=%0d busy=%b, expected 20/0", obs_count, obs_busy);
        end
        check_drained("rr");
    endtask

    task automatic test_back_pressure();
        logic [15:0] pat;
        do_reset();
        pat = 16'b0111_1011_0000_0110;
        load(2, 8'h60, 4);
        load(3, 8'h70, 4);
        expect_words(2, 8'h60, 4);
        expect_words(3, 8'h70, 4);
        drive();
        for (int t = 0; t < 16; t++) begin
            wfull = (t >= 3 && t <= 7);
            tick();
            checks++;
            if (obs_winc !== pat[t]) begin
                errors++;
                $display("FAIL stall_pattern t=%0d: got w_inc=%b, expected %b", t, obs_winc, pat[t]);
            end
            if (t >= 3 && t <= 7) begin
                checks++;
                if (obs_busy !== 1'b1 || obs_gid !== 2'd2) begin
                    errors++;
                    $display("FAIL stall_hold t=%0d: got busy=%b gid=%0d, expected 1/2", t, obs_busy, obs_gid);
                end
            end
        end
        wfull = 1'b0;
        check_drained("stall");
    endtask

    task automatic test_req_drop();
        do_reset();
        load(1, 8'h80, 1);
        expect_words(1, 8'h80, 1);
        expect_words(3, 8'hA0, 2);
        expect_words(0, 8'h90, 1);
        drive();
        for (int t = 0; t < 12; t++) begin
            tick();
            if (t == 0) begin
                load(0, 8'h90, 1);
                load(3, 8'hA0, 2);
                drive();
            end
            if (t == 2) begin
                checks++;
                if (obs_busy !== 1'b1 || obs_winc !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_grant: got busy=%b w_inc=%b, expected 1/0", obs_busy, obs_winc);
                end
            end
            if (t == 3) begin
                checks++;
                if (obs_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_idle: got busy=%b, expected 0", obs_busy);
                end
            end
            if (t == 4) begin
                checks++;
                if (obs_winc !== 1'b1 || obs_gid !== 2'd3) begin
                    errors++;
                    $display("FAIL drop_next: got w_inc=%b gid=%0d, expected 1/3", obs_winc, obs_gid);
                end
            end
        end
        check_drained("drop");
    endtask

    task automatic test_mid_reset();
        do_reset();
        load(0, 8'hD0, 8);
        load(2, 8'hE0, 4);
        expect_words(0, 8'hD0, 6);
        expect_words(2, 8'hE0, 4);
        expect_words(0, 8'hD6, 2);
        drive();
        for (int t = 0; t < 19; t++) begin
            if (t == 3) w_rst = 1'b1;
            if (t == 4) w_rst = 1'b0;
            tick();
            if (t == 3) begin
                checks++;
                if (obs_winc !== 1'b0 || obs_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_cycle: got w_inc=%b busy=%b, expected 0/0", obs_winc, obs_busy);
                end
            end
            if (t == 4) begin
                checks++;
                if (obs_count !== '0 || obs_busy !== 1'b0 || obs_gid !== 2'd0) begin
                    errors++;
                    $display("FAIL rst_after: got count=%0d busy=%b gid=%0d, expected 0/0/0",
                             obs_count, obs_busy, obs_gid);
                end
            end
            if (t == 5) begin
                checks++;
                if (obs_winc !== 1'b1 || obs_gid !== 2'd0) begin
                    errors++;
                    $display("FAIL rst_regrant: got w_inc=%b gid=%0d, expected 1/0", obs_winc, obs_gid);
                end
            end
        end
        checks++;
        if (obs_count !== 16'd10) begin
            errors++;
            $display("FAIL rst_count: got wr_count=%0d, expected 10", obs_count);
        end
        check_drained("rst");
    endtask

    task automatic test_enable();
        do_reset();
        load(0, 8'hB0, 4);
        load(1, 8'hC0, 4);
        expect_words(0, 8'hB0, 4);
        expect_words(1, 8'hC0, 4);
        drive();
        for (int t = 0; t < 14; t++) begin
            if (t == 2) en = 1'b0;
            if (t == 8) en = 1'b1;
            tick();
            if (t == 3 || t == 4) begin
                checks++;
                if (obs_winc !== 1'b1 || obs_gid !== 2'd0) begin
                    errors++;
                    $display("FAIL en_finish t=%0d: got w_inc=%b gid=%0d, expected 1/0", t, obs_winc, obs_gid);
                end
            end
            if (t >= 5 && t <= 8) begin
                checks++;
                if (obs_busy !== 1'b0 || obs_winc !== 1'b0) begin
                    errors++;
                    $display("FAIL en_hold t=%0d: got busy=%b w_inc=%b, expected 0/0", t, obs_busy, obs_winc);
                end
            end
            if (t == 9) begin
                checks++;
                if (obs_busy !== 1'b1 || obs_gid !== 2'd1 || obs_winc !== 1'b1) begin
                    errors++;
                    $display("FAIL en_regrant: got busy=%b gid=%0d w_inc=%b, expected 1/1/1",
                             obs_busy, obs_gid, obs_winc);
                end
            end
        end
        check_drained("en");
    endtask

    initial begin
        w_rst   = 1'b1;
        en      = 1'b0;
        wfull   = 1'b0;
        req     = '0;
        data_in = '0;
        #1;
        test_reset();
        test_single_requester();
        test_round_robin();
        test_back_pressure();
        test_req_drop();
        test_mid_reset();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
